mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single shared memory port of the pipelined core. It multiplexes two requesters onto one memory with fixed read latency: instruction fetch (IF) and data access (LDR/STR). Data access normally has priority. A starvation limit guarantees fetch progress. The block issues one access at a time, tracks its latency, and returns the read data or write completion to the owning requester.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter_lat_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int unsigned MAX_LAT    = 7;
    localparam int unsigned MAX_STARVE = 15;
    localparam int unsigned LAT_W      = 3;
    localparam int unsigned STARVE_W   = 4;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable 3-bit down-counter that tracks the remaining memory latency.
module lat_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic             done
);

    logic [LAT_W-1:0] count_q;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - LAT_W'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the shared fixed-latency memory port.
// Grants happen combinationally in IDLE; the response returns MEM_LAT cycles later.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [LAT_W-1:0]    LAT_LOAD  = LAT_W'(MEM_LAT - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
    localparam logic [STARVE_W-1:0] STARVE_SAT = STARVE_W'(MAX_STARVE);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                we_q, we_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                lat_load;
    logic                lat_done;
    logic                take_d;
    logic                take_if;

    lat_counter u_lat (
        .clk      (clk),
        .reset    (reset),
        .load     (lat_load),
        .load_val (LAT_LOAD),
        .done     (lat_done)
    );

    // Data wins unless fetch has already waited through STARVE_MAX data grants.
    assign take_d  = d_req && (!if_req || (starve_q < STARVE_LIM));
    assign take_if = if_req && !take_d;

    // State, ownership and starvation registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            we_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            starve_q <= starve_d;
        end
    end

    // Next-state, grant selection and output muxing; everything forced low in reset.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        starve_d  = starve_q;
        lat_load  = 1'b0;
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        d_gnt     = 1'b0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                if (take_d) begin
                    d_gnt     = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = d_we;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                    owner_d   = OWN_D;
                    we_d      = d_we;
                    lat_load  = 1'b1;
                    state_d   = WAIT;
                    if (if_req) begin
                        starve_d = (starve_q == STARVE_SAT) ? starve_q
                                                            : starve_q + STARVE_W'(1);
                    end else begin
                        starve_d = '0;
                    end
                end else if (take_if) begin
                    if_gnt   = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = if_addr;
                    owner_d  = OWN_IF;
                    we_d     = 1'b0;
                    lat_load = 1'b1;
                    state_d  = WAIT;
                    starve_d = '0;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (lat_done) begin
                    state_d = IDLE;
                    if (owner_q == OWN_D) begin
                        d_rvalid = 1'b1;
                        d_rdata  = we_q ? '0 : mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                end
            end
        endcase

        if (reset) begin
            lat_load  = 1'b0;
            if_gnt    = 1'b0;
            if_rvalid = 1'b0;
            if_rdata  = '0;
            d_gnt     = 1'b0;
            d_rvalid  = 1'b0;
            d_rdata   = '0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            busy      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: MEM_LAT=2/STARVE_MAX=4 main instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;

    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        if_req1, if_gnt1, if_rvalid1;
    logic [31:0] if_addr1, if_rdata1;
    logic        d_req1, d_we1, d_gnt1, d_rvalid1;
    logic [31:0] d_addr1, d_wdata1, d_rdata1;
    logic        mem_en1, mem_we1, busy1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

    int total;
    int bad;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0010;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0044; d_wdata = 32'h5555_AAAA;
        mem_rdata = 32'h0;
        if_req1 = 1'b0; if_addr1 = 32'h0; d_req1 = 1'b0; d_we1 = 1'b0;
        d_addr1 = 32'h0; d_wdata1 = 32'h0; mem_rdata1 = 32'h0;

        // Reset with requests present: everything low.
        #2;
        chk1("rst_if_gnt", if_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_busy", busy, 1'b0);

        // Release; idle with no request.
        tick();
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
        #1;
        chk1("idle_mem_en", mem_en, 1'b0);
        chk32("idle_mem_addr", mem_addr, 32'h0);
        chk32("idle_mem_wdata", mem_wdata, 32'h0);

        // Single load.
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040; d_wdata = 32'h0;
        #1;
        chk1("ld_d_gnt", d_gnt, 1'b1);
        chk1("ld_mem_en", mem_en, 1'b1);
        chk1("ld_mem_we", mem_we, 1'b0);
        chk32("ld_mem_addr", mem_addr, 32'h0000_0040);
        chk1("ld_busy_T", busy, 1'b0);
        tick();
        d_req = 1'b0; mem_rdata = 32'h7777_7777;
        #1;
        chk1("ld_busy_T1", busy, 1'b1);
        chk1("ld_mem_en_T1", mem_en, 1'b0);
        chk1("ld_rvalid_T1", d_rvalid, 1'b0);
        chk32("ld_rdata_T1", d_rdata, 32'h0);
        tick();
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk1("ld_rvalid_T2", d_rvalid, 1'b1);
        chk32("ld_rdata_T2", d_rdata, 32'hDEAD_BEEF);
        chk1("ld_busy_T2", busy, 1'b1);
        chk1("ld_if_rvalid_T2", if_rvalid, 1'b0);
        tick();
        mem_rdata = 32'h0;
        #1;
        chk1("ld_busy_T3", busy, 1'b0);
        chk1("ld_rvalid_T3", d_rvalid, 1'b0);

        // Store.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0080; d_wdata = 32'h1234_5678;
        #1;
        chk1("st_d_gnt", d_gnt, 1'b1);
        chk1("st_mem_we", mem_we, 1'b1);
        chk32("st_mem_addr", mem_addr, 32'h0000_0080);
        chk32("st_mem_wdata", mem_wdata, 32'h1234_5678);
        tick();
        d_req = 1'b0;
        tick();
        mem_rdata = 32'hAAAA_5555;
        #1;
        chk1("st_rvalid", d_rvalid, 1'b1);
        chk32("st_rdata_zero", d_rdata, 32'h0);
        tick();
        mem_rdata = 32'h0; d_we = 1'b0;

        // Simultaneous requests: data first, fetch once data drops.
        if_req = 1'b1; if_addr = 32'h0000_0200;
        d_req = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hFFFF_0000;
        #1;
        chk1("sim_d_gnt", d_gnt, 1'b1);
        chk1("sim_if_gnt_T", if_gnt, 1'b0);
        chk32("sim_mem_addr_T", mem_addr, 32'h0000_0100);
        tick();
        d_req = 1'b0;
        #1;
        chk1("sim_if_gnt_T1", if_gnt, 1'b0);
        tick();
        #1;
        chk1("sim_d_rvalid_T2", d_rvalid, 1'b1);
        chk1("sim_if_gnt_T2", if_gnt, 1'b0);
        tick();
        #1;
        chk1("sim_if_gnt_T3", if_gnt, 1'b1);
        chk32("sim_if_mem_addr", mem_addr, 32'h0000_0200);
        chk1("sim_if_mem_we", mem_we, 1'b0);
        chk32("sim_if_mem_wdata", mem_wdata, 32'h0);
        tick();
        if_req = 1'b0;
        tick();
        mem_rdata = 32'hCAFE_F00D;
        #1;
        chk1("sim_if_rvalid", if_rvalid, 1'b1);
        chk32("sim_if_rdata", if_rdata, 32'hCAFE_F00D);
        chk1("sim_d_rvalid_off", d_rvalid, 1'b0);
        chk32("sim_d_rdata_off", d_rdata, 32'h0);
        tick();
        mem_rdata = 32'h0;

        // Starvation: both held, expect D D D D IF D every 3 cycles.
        if_req = 1'b1; if_addr = 32'h0000_0300;
        d_req = 1'b1; d_addr = 32'h0000_0400;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk1($sformatf("stv_d_gnt_%0d", k), d_gnt, (k != 4));
            chk1($sformatf("stv_if_gnt_%0d", k), if_gnt, (k == 4));
            tick();
            #1;
            chk1($sformatf("stv_wait_en_%0d", k), mem_en, 1'b0);
            tick();
            #1;
            chk1($sformatf("stv_rv_d_%0d", k), d_rvalid, (k != 4));
            chk1($sformatf("stv_rv_if_%0d", k), if_rvalid, (k == 4));
            if (k == 5) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            tick();
        end
        #1;
        chk1("stv_idle_en", mem_en, 1'b0);

        // Reset mid-access.
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0500;
        #1;
        chk1("rma_if_gnt_T", if_gnt, 1'b1);
        tick();
        reset = 1'b1;
        #1;
        chk1("rma_busy", busy, 1'b0);
        chk1("rma_if_gnt", if_gnt, 1'b0);
        chk1("rma_mem_en", mem_en, 1'b0);
        chk32("rma_mem_addr", mem_addr, 32'h0);
        tick();
        mem_rdata = 32'h1111_1111;
        #1;
        chk1("rma_no_rvalid", if_rvalid, 1'b0);
        chk32("rma_rdata", if_rdata, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk1("rma_regrant", if_gnt, 1'b1);
        chk32("rma_regrant_addr", mem_addr, 32'h0000_0500);
        tick();
        if_req = 1'b0;
        tick();
        mem_rdata = 32'h2222_2222;
        #1;
        chk1("rma_rvalid", if_rvalid, 1'b1);
        chk32("rma_rdata2", if_rdata, 32'h2222_2222);
        tick();
        mem_rdata = 32'h0;

        // MEM_LAT=1: back-to-back fetches.
        if_req1 = 1'b1; if_addr1 = 32'h0000_0600;
        #1;
        chk1("l1_gnt_T", if_gnt1, 1'b1);
        chk32("l1_addr_T", mem_addr1, 32'h0000_0600);
        tick();
        mem_rdata1 = 32'h0101_0101;
        #1;
        chk1("l1_rvalid_T1", if_rvalid1, 1'b1);
        chk32("l1_rdata_T1", if_rdata1, 32'h0101_0101);
        chk1("l1_gnt_T1", if_gnt1, 1'b0);
        tick();
        mem_rdata1 = 32'h0;
        #1;
        chk1("l1_gnt_T2", if_gnt1, 1'b1);
        chk1("l1_rvalid_T2", if_rvalid1, 1'b0);
        tick();
        mem_rdata1 = 32'h0202_0202;
        #1;
        chk1("l1_rvalid_T3", if_rvalid1, 1'b1);
        chk32("l1_rdata_T3", if_rdata1, 32'h0202_0202);
        tick();
        mem_rdata1 = 32'h0;
        #1;
        chk1("l1_gnt_T4", if_gnt1, 1'b1);
        tick();
        if_req1 = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
